bp_update_queue: RTL

BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

---
 rtl/bp_update_queue_if.sv | 44 ++++
 rtl/bp_update_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue_if.sv
// bp_update_queue_if: bundles the fetch-side push, the execute-side resolve,
// the chooser update strobe and the status outputs of bp_update_queue.
//   slave  : the queue (drives full, count, upd_*, underflow_err, stat_*)
//   master : the pipeline (drives stall, flush, push_*, resolve_*)
// stat_* are always present; they read 0 unless the queue is built with
// BPQ_STATS_EN.
interface bp_update_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PHT_AW = 8
);
  logic                     stall;
  logic                     flush;
  logic                     push_valid;
  logic [PHT_AW-1:0]        push_addr;
  logic                     push_gh_pred;
  logic                     push_lh_pred;
  logic                     push_method;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     resolve_valid;
  logic                     resolve_taken;
  logic                     upd_valid;
  logic [PHT_AW-1:0]        upd_addr;
  logic                     upd_gh_correct;
  logic                     upd_lh_correct;
  logic                     upd_mispredict;
  logic                     underflow_err;
  logic [31:0]              stat_resolves;
  logic [31:0]              stat_mispred;

  modport slave (
    input  stall, flush, push_valid, push_addr, push_gh_pred, push_lh_pred,
           push_method, resolve_valid, resolve_taken,
    output full, count, upd_valid, upd_addr, upd_gh_correct, upd_lh_correct,
           upd_mispredict, underflow_err, stat_resolves, stat_mispred
  );

  modport master (
    output stall, flush, push_valid, push_addr, push_gh_pred, push_lh_pred,
           push_method, resolve_valid, resolve_taken,
    input  full, count, upd_valid, upd_addr, upd_gh_correct, upd_lh_correct,
           upd_mispredict, underflow_err, stat_resolves, stat_mispred
  );
endinterface

// File: rtl/bp_update_queue.sv
// bp_update_queue: in-order queue of predicted branches awaiting resolution.
// Each entry remembers the chooser index and both component predictions; when
// execute resolves the oldest branch, the entry is popped and, one cycle later,
// a chooser update (correctness of each predictor, mispredict of the chosen
// one) is emitted.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - bp_update_queue_if.slave (stall/flush, push, resolve, update,
//          full/count, sticky underflow_err, stat counters)
// Build option: define BPQ_STATS_EN to enable the 32-bit resolve/mispredict
// counters; otherwise stat_resolves/stat_mispred are tied to 0.
module bp_update_queue #(
  parameter int DEPTH  = 4,
  parameter int PHT_AW = 8
) (
  input logic               clk,
  input logic               rst,
  bp_update_queue_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PHT_AW-1:0] addr;
    logic              gh_pred;
    logic              lh_pred;
    logic              method;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              upd_valid_q, upd_valid_d;
  logic [PHT_AW-1:0] upd_addr_q, upd_addr_d;
  logic              upd_gh_correct_q, upd_gh_correct_d;
  logic              upd_lh_correct_q, upd_lh_correct_d;
  logic              upd_mispredict_q, upd_mispredict_d;
  logic              underflow_q, underflow_d;

  logic   active;
  logic   empty;
  logic   is_full;
  logic   pop;
  logic   push;
  logic   chosen;
  entry_t head;
  entry_t new_entry;

  always_comb begin
    active    = ~bus.stall;
    empty     = (count_q == '0);
    is_full   = (count_q == CW'(DEPTH));
    head      = mem_q[rd_ptr_q];
    chosen    = head.method ? head.lh_pred : head.gh_pred;
    pop       = bus.resolve_valid & active & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    push      = bus.push_valid & active & ~bus.flush & (~is_full | pop);
    new_entry = '{addr:    bus.push_addr,
                  gh_pred: bus.push_gh_pred,
                  lh_pred: bus.push_lh_pred,
                  method:  bus.push_method};

    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    upd_valid_d      = pop;
    upd_addr_d       = upd_addr_q;
    upd_gh_correct_d = upd_gh_correct_q;
    upd_lh_correct_d = upd_lh_correct_q;
    upd_mispredict_d = upd_mispredict_q;
    underflow_d      = underflow_q | (bus.resolve_valid & active & empty);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flush still lets the head's update go out, then empties the queue.
    // The write pointer never moves on a flush cycle since push is blocked.
    if (active && bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    if (pop) begin
      upd_addr_d       = head.addr;
      upd_gh_correct_d = (head.gh_pred == bus.resolve_taken);
      upd_lh_correct_d = (head.lh_pred == bus.resolve_taken);
      upd_mispredict_d = (chosen != bus.resolve_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      upd_valid_q      <= 1'b0;
      upd_addr_q       <= '0;
      upd_gh_correct_q <= 1'b0;
      upd_lh_correct_q <= 1'b0;
      upd_mispredict_q <= 1'b0;
      underflow_q      <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      upd_valid_q      <= upd_valid_d;
      upd_addr_q       <= upd_addr_d;
      upd_gh_correct_q <= upd_gh_correct_d;
      upd_lh_correct_q <= upd_lh_correct_d;
      upd_mispredict_q <= upd_mispredict_d;
      underflow_q      <= underflow_d;
    end
  end

`ifdef BPQ_STATS_EN
  logic [31:0] stat_resolves_q, stat_resolves_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Counted at the pop itself; flush does not touch them.
  always_comb begin
    stat_resolves_d = stat_resolves_q;
    stat_mispred_d  = stat_mispred_q;
    if (pop) begin
      stat_resolves_d = stat_resolves_q + 32'd1;
      if (chosen != bus.resolve_taken) stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolves_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolves_q <= stat_resolves_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign bus.stat_resolves = stat_resolves_q;
  assign bus.stat_mispred  = stat_mispred_q;
`else
  assign bus.stat_resolves = 32'd0;
  assign bus.stat_mispred  = 32'd0;
`endif

  assign bus.full           = is_full;
  assign bus.count          = count_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_addr       = upd_addr_q;
  assign bus.upd_gh_correct = upd_gh_correct_q;
  assign bus.upd_lh_correct = upd_lh_correct_q;
  assign bus.upd_mispredict = upd_mispredict_q;
  assign bus.underflow_err  = underflow_q;

endmodule
